// File: rtl/i3c_csr_cpuif_arb.sv
// ============================================================================
//  Module      : i3c_csr_cpuif_arb
//  Description : Round-robin arbiter sharing the single I3CCSR software access
//                port between NumReq bus front-ends. One transaction is in
//                flight at a time; ack/err/data are returned to the owner only.
//                Optional WAIT-state watchdog: define I3C_CSR_ARB_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i3c_csr_cpuif_arb #(
    parameter int NumReq        = 2,
    parameter int CsrAddrWidth  = 12,
    parameter int CsrDataWidth  = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NumReq-1:0]                u_req_i,
    input  logic [NumReq-1:0]                u_req_is_wr_i,
    input  logic [NumReq*CsrAddrWidth-1:0]   u_addr_i,
    input  logic [NumReq*CsrDataWidth-1:0]   u_wr_data_i,
    input  logic [NumReq*CsrDataWidth-1:0]   u_wr_biten_i,
    output logic [NumReq-1:0]                u_req_stall_o,
    output logic [NumReq-1:0]                u_rd_ack_o,
    output logic [NumReq-1:0]                u_rd_err_o,
    output logic [NumReq-1:0]                u_wr_ack_o,
    output logic [NumReq-1:0]                u_wr_err_o,
    output logic [CsrDataWidth-1:0]          u_rd_data_o,
    output logic                             m_req_o,
    output logic                             m_req_is_wr_o,
    output logic [CsrAddrWidth-1:0]          m_addr_o,
    output logic [CsrDataWidth-1:0]          m_wr_data_o,
    output logic [CsrDataWidth-1:0]          m_wr_biten_o,
    input  logic                             m_req_stall_wr_i,
    input  logic                             m_req_stall_rd_i,
    input  logic                             m_rd_ack_i,
    input  logic                             m_rd_err_i,
    input  logic                             m_wr_ack_i,
    input  logic                             m_wr_err_i,
    input  logic [CsrDataWidth-1:0]          m_rd_data_i
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         owner_q, owner_d;
    logic [IdxW-1:0]         last_q, last_d;
    logic                    is_wr_q, is_wr_d;
    logic [CsrAddrWidth-1:0] addr_q, addr_d;
    logic [CsrDataWidth-1:0] wdata_q, wdata_d;
    logic [CsrDataWidth-1:0] biten_q, biten_d;

    logic [IdxW-1:0]         w_start;
    logic [2*NumReq-1:0]     w_req_dbl;
    logic [NumReq-1:0]       w_req_rot;
    logic                    w_win_found;
    logic [IdxW-1:0]         w_win_idx;
    int                      w_off;
    int                      w_sum;
    logic                    w_sel_wr;
    logic [CsrAddrWidth-1:0] w_sel_addr;
    logic [CsrDataWidth-1:0] w_sel_wdata;
    logic [CsrDataWidth-1:0] w_sel_biten;
    logic                    w_m_stall, w_m_ack, w_m_err;
    logic                    w_fwd, w_fwd_err, w_fwd_tmo, w_accept, w_issue;
    logic                    w_tmo_hit;

    // Rotate the request vector so the search starts just after the last grant
    assign w_start   = (last_q == IdxW'(NumReq - 1)) ? '0 : last_q + 1'b1;
    assign w_req_dbl = {u_req_i, u_req_i} >> w_start;
    assign w_req_rot = w_req_dbl[NumReq-1:0];

    // Pick the first set request in rotated order and map back to a requester index
    always_comb begin
        w_win_found = 1'b0;
        w_off       = 0;
        for (int j = NumReq - 1; j >= 0; j--) begin
            if (w_req_rot[j]) begin
                w_win_found = 1'b1;
                w_off       = j;
            end
        end
        w_sum = int'(w_start) + w_off;
        if (w_sum >= NumReq) begin
            w_sum = w_sum - NumReq;
        end
        w_win_idx = IdxW'(w_sum);
    end

    // Select the winner's request fields for latching
    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_biten = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (w_win_idx == IdxW'(i)) begin
                w_sel_wr    = u_req_is_wr_i[i];
                w_sel_addr  = u_addr_i[i*CsrAddrWidth +: CsrAddrWidth];
                w_sel_wdata = u_wr_data_i[i*CsrDataWidth +: CsrDataWidth];
                w_sel_biten = u_wr_biten_i[i*CsrDataWidth +: CsrDataWidth];
            end
        end
    end

    // Only the handshake matching the latched direction matters
    assign w_m_stall = is_wr_q ? m_req_stall_wr_i : m_req_stall_rd_i;
    assign w_m_ack   = is_wr_q ? m_wr_ack_i       : m_rd_ack_i;
    assign w_m_err   = is_wr_q ? m_wr_err_i       : m_rd_err_i;

`ifdef I3C_CSR_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Watchdog counter: cleared while issuing, counts every WAIT cycle
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ISSUE) begin
            tmo_cnt_d = '0;
        end else if (state_q == WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign w_tmo_hit = (state_q == WAIT) && (tmo_cnt_q == 16'(TimeoutCycles));
`else
    // Watchdog compiled out: WAIT only ends on a real ack
    assign w_tmo_hit = (TimeoutCycles < 0);
`endif

    // Next-state logic and handshake decode
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        biten_d   = biten_q;
        w_accept  = 1'b0;
        w_issue   = 1'b0;
        w_fwd     = 1'b0;
        w_fwd_err = 1'b0;
        w_fwd_tmo = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_win_found) begin
                    w_accept = 1'b1;
                    owner_d  = w_win_idx;
                    last_d   = w_win_idx;
                    is_wr_d  = w_sel_wr;
                    addr_d   = w_sel_addr;
                    wdata_d  = w_sel_wdata;
                    biten_d  = w_sel_biten;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                w_issue = 1'b1;
                if (!w_m_stall) begin
                    if (w_m_ack) begin
                        w_fwd     = 1'b1;
                        w_fwd_err = w_m_err;
                        state_d   = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (w_m_ack) begin
                    w_fwd     = 1'b1;
                    w_fwd_err = w_m_err;
                    state_d   = IDLE;
                end else if (w_tmo_hit) begin
                    w_fwd     = 1'b1;
                    w_fwd_err = 1'b1;
                    w_fwd_tmo = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Upstream outputs; everything is quiet and stalled while in reset
    always_comb begin
        u_req_stall_o = '1;
        u_rd_ack_o    = '0;
        u_rd_err_o    = '0;
        u_wr_ack_o    = '0;
        u_wr_err_o    = '0;
        u_rd_data_o   = '0;
        m_req_o       = w_issue & ~rst;
        if (!rst) begin
            for (int i = 0; i < NumReq; i++) begin
                if (w_accept && (w_win_idx == IdxW'(i))) begin
                    u_req_stall_o[i] = 1'b0;
                end
                if (w_fwd && (owner_q == IdxW'(i))) begin
                    u_rd_ack_o[i] = ~is_wr_q;
                    u_rd_err_o[i] = ~is_wr_q & w_fwd_err;
                    u_wr_ack_o[i] = is_wr_q;
                    u_wr_err_o[i] = is_wr_q & w_fwd_err;
                end
            end
            if (w_fwd && !is_wr_q && !w_fwd_tmo) begin
                u_rd_data_o = m_rd_data_i;
            end
        end
    end

    assign m_req_is_wr_o = is_wr_q;
    assign m_addr_o      = addr_q;
    assign m_wr_data_o   = wdata_q;
    assign m_wr_biten_o  = biten_q;

    // State, owner, round-robin pointer and latched request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IdxW'(NumReq - 1);
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            biten_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            biten_q <= biten_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i3c_csr_cpuif_arb.sv
// ============================================================================
//  Module      : tb_i3c_csr_cpuif_arb
//  Description : Self-checking bench for i3c_csr_cpuif_arb with a behavioural
//                CSR responder and a scoreboard of expected transactions.
//                Watchdog scenario is built only with I3C_CSR_ARB_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i3c_csr_cpuif_arb;

    localparam int NR = 2;
    localparam int AW = 12;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    u_req_i, u_req_is_wr_i;
    logic [NR*AW-1:0] u_addr_i;
    logic [NR*DW-1:0] u_wr_data_i, u_wr_biten_i;
    logic [NR-1:0]    u_req_stall_o, u_rd_ack_o, u_rd_err_o, u_wr_ack_o, u_wr_err_o;
    logic [DW-1:0]    u_rd_data_o;
    logic             m_req_o, m_req_is_wr_o;
    logic [AW-1:0]    m_addr_o;
    logic [DW-1:0]    m_wr_data_o, m_wr_biten_o;
    logic             m_req_stall_wr_i, m_req_stall_rd_i;
    logic             m_rd_ack_i, m_rd_err_i, m_wr_ack_i, m_wr_err_i;
    logic [DW-1:0]    m_rd_data_i;

    i3c_csr_cpuif_arb #(
        .NumReq(NR), .CsrAddrWidth(AW), .CsrDataWidth(DW), .TimeoutCycles(8)
    ) dut (
        .clk(clk), .rst(rst),
        .u_req_i(u_req_i), .u_req_is_wr_i(u_req_is_wr_i), .u_addr_i(u_addr_i),
        .u_wr_data_i(u_wr_data_i), .u_wr_biten_i(u_wr_biten_i),
        .u_req_stall_o(u_req_stall_o), .u_rd_ack_o(u_rd_ack_o), .u_rd_err_o(u_rd_err_o),
        .u_wr_ack_o(u_wr_ack_o), .u_wr_err_o(u_wr_err_o), .u_rd_data_o(u_rd_data_o),
        .m_req_o(m_req_o), .m_req_is_wr_o(m_req_is_wr_o), .m_addr_o(m_addr_o),
        .m_wr_data_o(m_wr_data_o), .m_wr_biten_o(m_wr_biten_o),
        .m_req_stall_wr_i(m_req_stall_wr_i), .m_req_stall_rd_i(m_req_stall_rd_i),
        .m_rd_ack_i(m_rd_ack_i), .m_rd_err_i(m_rd_err_i),
        .m_wr_ack_i(m_wr_ack_i), .m_wr_err_i(m_wr_err_i), .m_rd_data_i(m_rd_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          owner;
        bit          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] biten;
        logic [DW-1:0] rdata;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t rq0[$];
    exp_t rq1[$];

    int checks = 0;
    int passed = 0;
    int tick_n = 0;
    int issued = 0;
    logic [NR-1:0] acc = '0;
    int  csr_stall_left = 0;
    int  csr_stall_seen = 0;
    bit  csr_same = 0, csr_noack = 0, csr_spur = 0, csr_pend = 0, csr_pend_wr = 0;
    logic [DW-1:0] csr_rdata = '0;
    bit  raise1 = 0, kill1 = 0;

    // Queue a request for requester k and its expected completion
    task automatic post(input int k, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] be,
                        input logic [DW-1:0] rd, input bit err);
        exp_t e;
        e.owner = k; e.wr = wr; e.addr = addr; e.wdata = wd;
        e.biten = be; e.rdata = rd; e.err = err;
        exp_q.push_back(e);
        if (k == 0) rq0.push_back(e);
        else        rq1.push_back(e);
    endtask

    // One clock: requester agents and CSR responder drive at negedge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        tick_n++;
        for (int k = 0; k < NR; k++) if (acc[k]) u_req_i[k] = 1'b0;
        if (kill1) begin u_req_i[1] = 1'b0; kill1 = 0; end
        if (raise1) begin
            u_req_i[1] = 1'b1; u_req_is_wr_i[1] = 1'b1; u_addr_i[AW +: AW] = 12'h0EE;
            u_wr_data_i[DW +: DW] = 32'hFFFF_0000; u_wr_biten_i[DW +: DW] = '1; raise1 = 0;
        end
        if (!u_req_i[0] && rq0.size() > 0) begin
            e = rq0.pop_front();
            u_req_i[0] = 1'b1; u_req_is_wr_i[0] = e.wr; u_addr_i[0 +: AW] = e.addr;
            u_wr_data_i[0 +: DW] = e.wdata; u_wr_biten_i[0 +: DW] = e.biten;
        end
        if (!u_req_i[1] && rq1.size() > 0) begin
            e = rq1.pop_front();
            u_req_i[1] = 1'b1; u_req_is_wr_i[1] = e.wr; u_addr_i[AW +: AW] = e.addr;
            u_wr_data_i[DW +: DW] = e.wdata; u_wr_biten_i[DW +: DW] = e.biten;
        end
        m_rd_ack_i = 0; m_wr_ack_i = 0; m_rd_err_i = 0; m_wr_err_i = 0;
        m_req_stall_wr_i = 0; m_req_stall_rd_i = 0; m_rd_data_i = 32'hBAD0_BAD0;
        if (csr_spur) begin
            m_rd_ack_i = 1; m_rd_data_i = 32'h1234_5678; csr_spur = 0;
        end else if (csr_pend) begin
            if (csr_pend_wr) m_wr_ack_i = 1;
            else begin m_rd_ack_i = 1; m_rd_data_i = csr_rdata; end
            csr_pend = 0;
        end else if (m_req_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL csr_issue: m_req_o=1 but no transaction expected (addr %h)", m_addr_o);
            end else if ({m_req_is_wr_o, m_addr_o, m_wr_data_o, m_wr_biten_o} !==
                         {exp_q[0].wr, exp_q[0].addr, exp_q[0].wdata, exp_q[0].biten}) begin
                $display("FAIL csr_fields: got wr=%b addr=%h wd=%h be=%h want wr=%b addr=%h wd=%h be=%h",
                         m_req_is_wr_o, m_addr_o, m_wr_data_o, m_wr_biten_o,
                         exp_q[0].wr, exp_q[0].addr, exp_q[0].wdata, exp_q[0].biten);
            end else passed++;
            if (csr_stall_left > 0) begin
                if (m_req_is_wr_o) m_req_stall_wr_i = 1; else m_req_stall_rd_i = 1;
                csr_stall_left--; csr_stall_seen++;
            end else begin
                issued++;
                csr_rdata = (exp_q.size() > 0) ? exp_q[0].rdata : '0;
                if (csr_same) begin
                    if (m_req_is_wr_o) m_wr_ack_i = 1;
                    else begin m_rd_ack_i = 1; m_rd_data_i = csr_rdata; end
                end else if (!csr_noack) begin
                    csr_pend = 1; csr_pend_wr = m_req_is_wr_o;
                end
            end
        end
        #1;
        acc = u_req_i & ~u_req_stall_o;
    endtask

    // Scoreboard: every upstream completion must match the oldest expectation
    initial begin
        exp_t e;
        logic [NR-1:0] oh;
        forever begin
            @(negedge clk);
            #2;
            if ((|u_rd_ack_o) || (|u_wr_ack_o)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: rd_ack=%b wr_ack=%b data=%h with nothing outstanding",
                             u_rd_ack_o, u_wr_ack_o, u_rd_data_o);
                end else begin
                    e = exp_q.pop_front();
                    oh = '0; oh[e.owner] = 1'b1;
                    if ({u_rd_ack_o, u_wr_ack_o, u_rd_err_o, u_wr_err_o, u_rd_data_o} !==
                        {(e.wr ? '0 : oh), (e.wr ? oh : '0), ((!e.wr && e.err) ? oh : '0),
                         ((e.wr && e.err) ? oh : '0), (e.wr ? '0 : e.rdata)}) begin
                        $display("FAIL sb_completion: got rack=%b wack=%b rerr=%b werr=%b data=%h want owner=%0d wr=%b err=%b data=%h",
                                 u_rd_ack_o, u_wr_ack_o, u_rd_err_o, u_wr_err_o, u_rd_data_o,
                                 e.owner, e.wr, e.err, e.wr ? 32'h0 : e.rdata);
                    end else passed++;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1; u_req_i = '0; acc = '0;
        rq0.delete(); rq1.delete(); exp_q.delete();
        csr_stall_left = 0; csr_same = 0; csr_noack = 0; csr_spur = 0; csr_pend = 0;
        repeat (2) tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({u_req_stall_o, m_req_o, u_rd_ack_o, u_wr_ack_o, u_rd_err_o, u_wr_err_o} !== {2'b11, 1'b0, 8'h00}) begin
                $display("FAIL reset_outputs: stall=%b mreq=%b rack=%b wack=%b want stall=11 mreq=0 acks=0",
                         u_req_stall_o, m_req_o, u_rd_ack_o, u_wr_ack_o);
            end else passed++;
        end
        checks++;
        if ({m_req_is_wr_o, m_addr_o, m_wr_data_o, m_wr_biten_o, u_rd_data_o} !== '0) begin
            $display("FAIL reset_fields: wr=%b addr=%h wd=%h be=%h rdata=%h want all 0",
                     m_req_is_wr_o, m_addr_o, m_wr_data_o, m_wr_biten_o, u_rd_data_o);
        end else passed++;
        rst = 0;
    endtask

    task automatic test_single_read();
        int t_acc = -1, t_mreq = -1, t_ack = -1;
        bit saw1 = 0;
        post(0, 1'b0, 12'h010, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 20 && t_ack < 0; i++) begin
            tick();
            if (acc[0] && t_acc < 0) t_acc = tick_n;
            if (m_req_o && t_mreq < 0) t_mreq = tick_n;
            if (u_rd_ack_o[1] || u_wr_ack_o[1]) saw1 = 1;
            if (u_rd_ack_o != 0) begin
                t_ack = tick_n;
                checks++;
                if ({u_rd_ack_o, u_rd_data_o} !== {2'b01, 32'hDEAD_BEEF}) begin
                    $display("FAIL single_read_ack: rack=%b data=%h want 01 deadbeef", u_rd_ack_o, u_rd_data_o);
                end else passed++;
            end
        end
        checks++;
        if (t_ack < 0 || t_mreq != t_acc + 1 || t_ack != t_acc + 2) begin
            $display("FAIL single_read_latency: accept=%0d mreq=%0d ack=%0d want mreq=accept+1 ack=accept+2",
                     t_acc, t_mreq, t_ack);
        end else passed++;
        checks++;
        if (saw1 !== 1'b0) $display("FAIL single_read_other: requester1 acked=%b want 0", saw1);
        else passed++;
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        int t1 = -1, t2 = -1;
        post(0, 1'b1, 12'h030, 32'h1111_2222, 32'h0000_FFFF, 32'h0, 1'b0);
        post(0, 1'b0, 12'h034, 32'h0, 32'h0, 32'hCAFE_0034, 1'b0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            tick();
            if (acc[0]) begin if (t1 < 0) t1 = tick_n; else t2 = tick_n; end
        end
        checks++;
        if (t2 < 0 || t2 != t1 + 3) $display("FAIL back_to_back_gap: second accept gap=%0d want 3", t2 - t1);
        else passed++;
        repeat (2) tick();
    endtask

    task automatic test_contention();
        int grants[$];
        bit multi = 0;
        do_reset();
        post(0, 1'b0, 12'h100, 32'h0, 32'h0, 32'hA000_0100, 1'b0);
        post(1, 1'b1, 12'h104, 32'h0BAD_F00D, 32'hFFFF_FFFF, 32'h0, 1'b0);
        post(0, 1'b1, 12'h108, 32'h0000_0108, 32'h00FF_00FF, 32'h0, 1'b0);
        post(1, 1'b0, 12'h10C, 32'h0, 32'h0, 32'hB000_010C, 1'b0);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            tick();
            if ($countones(acc) > 1) multi = 1;
            if (acc[0]) grants.push_back(0);
            if (acc[1]) grants.push_back(1);
        end
        checks++;
        if (grants.size() != 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
            $display("FAIL contention_order: %0d grants, first=%0d want 4 grants 0,1,0,1",
                     grants.size(), grants.size() > 0 ? grants[0] : -1);
        end else passed++;
        checks++;
        if (multi !== 1'b0) $display("FAIL contention_single_accept: multiple accepts=%b want 0", multi);
        else passed++;
        repeat (2) tick();
    endtask

    task automatic test_stall();
        int mreq_cyc = 0, wacks = 0;
        csr_stall_seen = 0;
        csr_stall_left = 5;
        post(0, 1'b1, 12'h020, 32'h0000_55AA, 32'hFFFF_FFFF, 32'h0, 1'b0);
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
            tick();
            if (m_req_o) mreq_cyc++;
            if (u_wr_ack_o == 2'b01) wacks++;
        end
        repeat (3) begin
            tick();
            if (u_wr_ack_o != 0) wacks++;
        end
        checks++;
        if (csr_stall_seen != 5 || mreq_cyc != 6) begin
            $display("FAIL stall_hold: stalled=%0d mreq cycles=%0d want 5 and 6", csr_stall_seen, mreq_cyc);
        end else passed++;
        checks++;
        if (wacks != 1) $display("FAIL stall_ack_count: wr acks=%0d want 1", wacks);
        else passed++;
    endtask

    task automatic test_same_cycle();
        int t1 = -1, t2 = -1, ta = -1;
        csr_same = 1;
        post(1, 1'b0, 12'h040, 32'h0, 32'h0, 32'hA5A5_0040, 1'b0);
        post(1, 1'b1, 12'h044, 32'h0000_0044, 32'hFFFF_0000, 32'h0, 1'b0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            tick();
            if (u_rd_ack_o[1] && ta < 0) ta = tick_n;
            if (acc[1]) begin if (t1 < 0) t1 = tick_n; else t2 = tick_n; end
        end
        checks++;
        if (ta != t1 + 1 || t2 != t1 + 2) begin
            $display("FAIL same_cycle_timing: accept=%0d ack=%0d next=%0d want ack=+1 next=+2", t1, ta, t2);
        end else passed++;
        csr_same = 0;
        repeat (2) tick();
    endtask

    task automatic test_spurious();
        csr_spur = 1;
        tick();
        checks++;
        if ({u_rd_ack_o, u_rd_err_o, u_rd_data_o} !== '0) begin
            $display("FAIL spurious_ack: rack=%b rerr=%b data=%h want all 0", u_rd_ack_o, u_rd_err_o, u_rd_data_o);
        end else passed++;
        tick();
    endtask

    task automatic test_withdraw();
        int iss0 = issued;
        bit got1 = 0;
        post(0, 1'b0, 12'h050, 32'h0, 32'h0, 32'h5050_5050, 1'b0);
        tick();
        raise1 = 1;
        tick(); if (acc[1]) got1 = 1;
        tick(); if (acc[1]) got1 = 1;
        kill1 = 1;
        for (int i = 0; i < 5; i++) begin tick(); if (acc[1]) got1 = 1; end
        checks++;
        if (got1 !== 1'b0 || issued != iss0 + 1 || exp_q.size() != 0) begin
            $display("FAIL withdraw: accepted1=%b issued=%0d pending=%0d want 0 1 0",
                     got1, issued - iss0, exp_q.size());
        end else passed++;
    endtask

    task automatic test_reset_mid();
        csr_noack = 1;
        post(0, 1'b0, 12'h060, 32'h0, 32'h0, 32'h6060_6060, 1'b0);
        for (int i = 0; i < 10 && !m_req_o; i++) tick();
        repeat (2) tick();
        rst = 1;
        tick();
        checks++;
        if ({u_req_stall_o, m_req_o} !== 3'b110) begin
            $display("FAIL reset_mid: stall=%b mreq=%b want 11 0", u_req_stall_o, m_req_o);
        end else passed++;
        exp_q.delete(); csr_noack = 0; csr_pend = 0;
        tick();
        rst = 0;
        post(0, 1'b0, 12'h064, 32'h0, 32'h0, 32'h0000_0064, 1'b0);
        post(1, 1'b0, 12'h068, 32'h0, 32'h0, 32'h0000_0068, 1'b0);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) $display("FAIL reset_mid_recover: %0d outstanding want 0", exp_q.size());
        else passed++;
        repeat (2) tick();
    endtask

`ifdef I3C_CSR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int t_m = -1, t_a = -1;
        csr_noack = 1;
        post(0, 1'b0, 12'h070, 32'h0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 40 && t_a < 0; i++) begin
            tick();
            if (m_req_o && t_m < 0) t_m = tick_n;
            if (u_rd_ack_o != 0) t_a = tick_n;
        end
        checks++;
        if (t_a < 0 || t_a != t_m + 9) $display("FAIL timeout_latency: issue=%0d ack=%0d want issue+9", t_m, t_a);
        else passed++;
        csr_noack = 0;
        tick();
        csr_spur = 1;
        tick();
        checks++;
        if ({u_rd_ack_o, u_rd_data_o} !== '0) $display("FAIL timeout_late_ack: rack=%b data=%h want 0", u_rd_ack_o, u_rd_data_o);
        else passed++;
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1; u_req_i = '0; u_req_is_wr_i = '0; u_addr_i = '0;
        u_wr_data_i = '0; u_wr_biten_i = '0;
        m_req_stall_wr_i = 0; m_req_stall_rd_i = 0; m_rd_ack_i = 0; m_rd_err_i = 0;
        m_wr_ack_i = 0; m_wr_err_i = 0; m_rd_data_i = '0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_contention();
        test_stall();
        test_same_cycle();
        test_spurious();
        test_withdraw();
        test_reset_mid();
`ifdef I3C_CSR_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) $display("FAIL final_drain: %0d outstanding want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
